score_digit_ctrl: RTL and testbench
===================================

# score_digit_ctrl

Controller that shares the 25×30 digit glyph ROMs among the three digits of an on-screen score readout. It converts a 10-bit binary score to BCD with a multi-cycle double-dabble sequencer, commits new digits only at frame start to avoid tearing, and drives ROM row/col/digit-select from the VGA pixel position. It re-aligns the 1-cycle registered ROM output with the pixel stream and emits a foreground pixel plus an enable for the top-level colour mux.

## Interface
- X0, 10'd280: left x of the hundreds digit box.
- Y0, 10'd20: top y of all digit boxes.
- GAP, 5: blank columns between adjacent digit boxes.
- FG_COLOR, 12'hFF0: colour driven for glyph pixels.

- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- score  in  10  binary score; values above 999 saturate to 999.
- score_load  in  1  1-cycle pulse; samples score.
- frame_start  in  1  1-cycle pulse at the first pixel of each frame.
- busy  out  1  conversion or commit pending.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- video_on  in  1  pixel is in the visible area.
- rom_row  out  5  glyph row 0–29 to the ROMs.
- rom_col  out  5  glyph column 0–24 to the ROMs.
- rom_sel  out  4  digit value 0–9; the external mux selects that ROM's color_data.
- rom_data  in  12  muxed ROM color_data, valid 1 cycle after row/col.
- pixel_on  out  1  glyph pixel present.
- pixel_color  out  12  FG_COLOR when pixel_on, else 0.

## Operation
- FSM states: IDLE, CONV, WAIT_FRAME, COMMIT.
- IDLE:
  - On score_load, latch min(score, 999) into a 10-bit shift register, clear the 12-bit BCD register and set the bit counter to 10.
  - Go to CONV.
- CONV, one bit per cycle:
  - Each BCD nibble ≥5 gets +3.
  - The {BCD, bin} register then shifts left by 1.
  - After the 10th shift, go to WAIT_FRAME.
- WAIT_FRAME: hold until frame_start, then go to COMMIT.
- COMMIT: copy the BCD result to the display digit registers (hund, tens, ones), then go to IDLE.
- busy = 1 in CONV, WAIT_FRAME and COMMIT.
- score_load is ignored while busy = 1; it is not queued.
- frame_start in IDLE or CONV has no effect.
- Box k (0 = hund, 1 = tens, 2 = ones):
  - x in [X0 + k·(25+GAP), X0 + k·(25+GAP) + 24];
  - y in [Y0, Y0 + 29];
  - video_on = 1.
- Inside box k:
  - rom_row = y − Y0;
  - rom_col = x − box start;
  - rom_sel = digit k.
- Outside all boxes: rom_row, rom_col and rom_sel are 0.
- Leading-zero suppression:
  - hund is blank when 0.
  - tens is blank when hund = 0 and tens = 0.
  - ones is never blank.
- Glyph pixel: a pixel is a glyph pixel when the delayed in-box flag = 1, the delayed blank flag = 0 and rom_data = 12'h000. ROM white is background; any non-zero value is background.
- Box arithmetic is done at 11 bits so X0 + 84 cannot wrap.

## Timing
- Reset:
  - FSM to IDLE, busy = 0.
  - Digits = 0, so the display shows "0".
  - rom_row, rom_col and rom_sel = 0.
  - pixel_on = 0, pixel_color = 0.
  - Pipeline valid/blank flags cleared.
  - Reset mid-CONV discards the conversion; the digits return to 0.
- Pixel pipeline, for x/y sampled in cycle N:
  - rom_row, rom_col, rom_sel and the in-box/blank flags are registered and valid in N+1.
  - rom_data is valid in N+2.
  - pixel_on and pixel_color are registered and valid in N+3.
  - Fixed latency is 3; the top level delays its other sprites to match.
- Score update:
  - score_load in cycle L gives CONV from L+1 to L+10 and WAIT_FRAME from L+11.
  - frame_start in cycle F ≥ L+11 gives COMMIT in F+1.
  - New digits are visible to the pipeline from F+2, and busy falls in F+2.
  - frame_start coincident with the transition into WAIT_FRAME (cycle L+11) is recognised.
- Digit registers change only in COMMIT, so a frame never mixes old and new digits.

## Test plan
- Reset, then scan box 2 with score never loaded:
  - pixel_on pattern equals the "0" glyph;
  - boxes 0 and 1 give pixel_on = 0;
  - latency is exactly 3 cycles from x/y.
- score_load with score = 307, then frame_start at L+15:
  - busy is 1 from L+1 to F+1;
  - digits become 3/0/7 at F+2;
  - tens is not blank;
  - at (X0, Y0) rom_sel = 3 with row/col = 0/0.
- score = 1023:
  - digits commit as 9/9/9 (saturation).
- score = 5:
  - hund and tens are blank (pixel_on = 0 even where rom_data = 0);
  - ones shows 5.
- Second score_load at L+4 with a different value:
  - it is ignored, and the first value commits.
- Reset asserted during CONV (cycle L+5):
  - busy = 0 and digits = 0 in the next cycle;
  - a later frame_start commits nothing;
  - pixel at box 2 (x = X0 + 60, y = Y0) with video_on = 0 gives pixel_on = 0.

Source files
------------

// File: rtl/score_digit_ctrl_if.sv
// Score-readout bundle: score update handshake, pixel position in, ROM address/data, pixel out.
// master = score source / video timing / ROM side, slave = score_digit_ctrl.
interface score_digit_ctrl_if;
    logic [9:0]  score;
    logic        score_load;
    logic        frame_start;
    logic        busy;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic [4:0]  rom_row;
    logic [4:0]  rom_col;
    logic [3:0]  rom_sel;
    logic [11:0] rom_data;
    logic        pixel_on;
    logic [11:0] pixel_color;

    modport master (
        output score, score_load, frame_start, x, y, video_on, rom_data,
        input  busy, rom_row, rom_col, rom_sel, pixel_on, pixel_color
    );

    modport slave (
        input  score, score_load, frame_start, x, y, video_on, rom_data,
        output busy, rom_row, rom_col, rom_sel, pixel_on, pixel_color
    );
endinterface

// File: rtl/score_digit_ctrl.sv
// Three-digit score readout: serial binary-to-BCD, frame-synchronous digit commit, shared glyph ROM addressing.
// Pixel latency 3 cycles (x/y -> pixel_on); score_load is dropped while busy, never queued.
module score_digit_ctrl #(
    parameter logic [9:0]  X0       = 10'd280,
    parameter logic [9:0]  Y0       = 10'd20,
    parameter int          GAP      = 5,
    parameter logic [11:0] FG_COLOR = 12'hFF0
) (
    input  logic              clk,
    input  logic              reset,
    score_digit_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, WAIT_FRAME, COMMIT} state_t;

    localparam logic [10:0] PITCH = 11'(25 + GAP);
    localparam logic [10:0] B0_X  = {1'b0, X0};
    localparam logic [10:0] B1_X  = B0_X + PITCH;
    localparam logic [10:0] B2_X  = B0_X + 11'd2 * PITCH;
    localparam logic [10:0] Y0_W  = {1'b0, Y0};

    state_t      state_q;
    logic [9:0]  bin_q;
    logic [11:0] bcd_q;
    logic [3:0]  cnt_q;
    logic [3:0]  hund_q, tens_q, ones_q;
    logic        busy_q;

    logic [9:0]  score_sat;
    logic [11:0] bcd_adj;

    assign score_sat = (bus.score > 10'd999) ? 10'd999 : bus.score;

    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0]   >= 4'd5) bcd_adj[3:0]   = bcd_q[3:0]   + 4'd3;
        if (bcd_q[7:4]   >= 4'd5) bcd_adj[7:4]   = bcd_q[7:4]   + 4'd3;
        if (bcd_q[11:8]  >= 4'd5) bcd_adj[11:8]  = bcd_q[11:8]  + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.score_load) begin
                        bin_q   <= score_sat;
                        bcd_q   <= '0;
                        cnt_q   <= 4'd10;
                        state_q <= CONV;
                        busy_q  <= 1'b1;
                    end
                end
                CONV: begin
                    {bcd_q, bin_q} <= {bcd_adj[10:0], bin_q, 1'b0};
                    cnt_q          <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (bus.frame_start) state_q <= COMMIT;
                end
                COMMIT: begin
                    hund_q  <= bcd_q[11:8];
                    tens_q  <= bcd_q[7:4];
                    ones_q  <= bcd_q[3:0];
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Unsigned 11-bit offsets: a pixel left of a box wraps to a large value and fails the < test.
    logic [10:0] x_w, y_w, dx0, dx1, dx2, dy;
    assign x_w = {1'b0, bus.x};
    assign y_w = {1'b0, bus.y};
    assign dx0 = x_w - B0_X;
    assign dx1 = x_w - B1_X;
    assign dx2 = x_w - B2_X;
    assign dy  = y_w - Y0_W;

    logic [4:0] row_d, col_d;
    logic [3:0] sel_d;
    logic       inbox_d, blank_d;

    always_comb begin
        row_d   = '0;
        col_d   = '0;
        sel_d   = '0;
        inbox_d = 1'b0;
        blank_d = 1'b0;
        if (bus.video_on && dy < 11'd30) begin
            if (dx0 < 11'd25) begin
                inbox_d = 1'b1;
                row_d   = dy[4:0];
                col_d   = dx0[4:0];
                sel_d   = hund_q;
                blank_d = (hund_q == 4'd0);
            end else if (dx1 < 11'd25) begin
                inbox_d = 1'b1;
                row_d   = dy[4:0];
                col_d   = dx1[4:0];
                sel_d   = tens_q;
                blank_d = (hund_q == 4'd0) && (tens_q == 4'd0);
            end else if (dx2 < 11'd25) begin
                inbox_d = 1'b1;
                row_d   = dy[4:0];
                col_d   = dx2[4:0];
                sel_d   = ones_q;
            end
        end
    end

    logic [4:0]  rom_row_q, rom_col_q;
    logic [3:0]  rom_sel_q;
    logic        inbox1_q, blank1_q, inbox2_q, blank2_q;
    logic        pixel_on_q;
    logic [11:0] pixel_color_q;
    logic        pixel_on_d;

    // Flags are held one extra stage so they line up with the ROM's registered output.
    assign pixel_on_d = inbox2_q && !blank2_q && (bus.rom_data == 12'h000);

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_row_q     <= '0;
            rom_col_q     <= '0;
            rom_sel_q     <= '0;
            inbox1_q      <= 1'b0;
            blank1_q      <= 1'b0;
            inbox2_q      <= 1'b0;
            blank2_q      <= 1'b0;
            pixel_on_q    <= 1'b0;
            pixel_color_q <= '0;
        end else begin
            rom_row_q     <= row_d;
            rom_col_q     <= col_d;
            rom_sel_q     <= sel_d;
            inbox1_q      <= inbox_d;
            blank1_q      <= blank_d;
            inbox2_q      <= inbox1_q;
            blank2_q      <= blank1_q;
            pixel_on_q    <= pixel_on_d;
            pixel_color_q <= pixel_on_d ? FG_COLOR : 12'h000;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.rom_row     = rom_row_q;
    assign bus.rom_col     = rom_col_q;
    assign bus.rom_sel     = rom_sel_q;
    assign bus.pixel_on    = pixel_on_q;
    assign bus.pixel_color = pixel_color_q;
endmodule

// File: tb/tb_score_digit_ctrl.sv
// Randomized bench for score_digit_ctrl against a decimal/box-geometry reference model and a behavioural glyph ROM.
module tb_score_digit_ctrl;
    localparam int X0 = 280;
    localparam int Y0 = 20;
    localparam int PITCH = 30;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    score_digit_ctrl_if bus ();

    score_digit_ctrl #(
        .X0(10'd280), .Y0(10'd20), .GAP(5), .FG_COLOR(12'hFF0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int m_dig[3];
    int sx[400], sy[400], sv[400];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Synthetic glyph set: 0 is ink, any non-zero value is background.
    function automatic logic [11:0] glyph(input int d, input int r, input int c);
        if (((d * 7 + r * 3 + c * 5) % 5) < 2) return 12'h000;
        return 12'h800 | 12'(c);
    endfunction

    always @(posedge clk) bus.rom_data <= glyph(int'(bus.rom_sel), int'(bus.rom_row), int'(bus.rom_col));

    function automatic int exp_box(input int x, input int y, input int v);
        if (v == 0 || y < Y0 || y > Y0 + 29) return -1;
        for (int k = 0; k < 3; k++)
            if (x >= X0 + k * PITCH && x <= X0 + k * PITCH + 24) return k;
        return -1;
    endfunction

    function automatic bit exp_blank(input int k);
        if (k == 0) return m_dig[0] == 0;
        if (k == 1) return m_dig[0] == 0 && m_dig[1] == 0;
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.score_load  = 1'b0;
        bus.frame_start = 1'b0;
        bus.score       = '0;
        bus.x           = '0;
        bus.y           = '0;
        bus.video_on    = 1'b0;
    endtask

    // Entries [0, n_dir) of sx/sy/sv are set by the caller; the rest are randomized here.
    task automatic run_scan(input int n, input int n_dir);
        int b, er, ec, eon;
        for (int i = n_dir; i < n; i++) begin
            sx[i] = $urandom_range(X0 - 3, X0 + 90);
            sy[i] = $urandom_range(Y0 - 2, Y0 + 32);
            sv[i] = ($urandom % 8) != 0;
        end
        for (int c = 0; c < n + 3; c++) begin
            step();
            if (c >= 1 && c - 1 < n) begin
                b  = exp_box(sx[c-1], sy[c-1], sv[c-1]);
                er = (b >= 0) ? sy[c-1] - Y0 : 0;
                ec = (b >= 0) ? sx[c-1] - (X0 + b * PITCH) : 0;
                check("rom_row", int'(bus.rom_row), er);
                check("rom_col", int'(bus.rom_col), ec);
                check("rom_sel", int'(bus.rom_sel), (b >= 0) ? m_dig[b] : 0);
            end
            if (c >= 3) begin
                b   = exp_box(sx[c-3], sy[c-3], sv[c-3]);
                eon = 0;
                if (b >= 0 && !exp_blank(b))
                    eon = (glyph(m_dig[b], sy[c-3] - Y0, sx[c-3] - (X0 + b * PITCH)) == 12'h000);
                check("pixel_on", int'(bus.pixel_on), eon);
                check("pixel_color", int'(bus.pixel_color), eon ? 12'hFF0 : 0);
            end
            if (c < n) begin
                bus.x        = 10'(sx[c]);
                bus.y        = 10'(sy[c]);
                bus.video_on = sv[c] != 0;
            end else begin
                drive_idle();
            end
        end
    endtask

    task automatic set_edges();
        sx[0] = X0;           sy[0] = Y0;      sv[0] = 1;
        sx[1] = X0 + 24;      sy[1] = Y0 + 29; sv[1] = 1;
        sx[2] = X0 + 25;      sy[2] = Y0 + 5;  sv[2] = 1;
        sx[3] = X0 + 30;      sy[3] = Y0 + 30; sv[3] = 1;
        sx[4] = X0 + 84;      sy[4] = Y0 + 10; sv[4] = 1;
        sx[5] = X0 + 85;      sy[5] = Y0 + 10; sv[5] = 1;
        sx[6] = X0 - 1;       sy[6] = Y0;      sv[6] = 1;
        sx[7] = X0 + 60;      sy[7] = Y0 - 1;  sv[7] = 1;
    endtask

    // score_load at t=0; frame_start at t=fdly (>=11) plus an optional early one that must be ignored.
    task automatic run_update(input int sc, input int fdly, input int extra_at, input int extra_sc, input int early_fs);
        int v, old_ones;
        v = (sc > 999) ? 999 : sc;
        old_ones = m_dig[2];
        for (int t = 0; t <= fdly + 3; t++) begin
            step();
            check("busy", int'(bus.busy), (t >= 1 && t <= fdly + 1) ? 1 : 0);
            if (t == fdly + 2) check("sel_before_commit", int'(bus.rom_sel), old_ones);
            if (t == fdly + 3) check("sel_after_commit", int'(bus.rom_sel), v % 10);
            bus.score_load  = (t == 0) || (t == extra_at);
            bus.score       = 10'((t == 0) ? sc : extra_sc);
            bus.frame_start = (t == fdly) || (t == early_fs);
            if (t == fdly + 1 || t == fdly + 2) begin
                bus.x = 10'(X0 + 60); bus.y = 10'(Y0); bus.video_on = 1'b1;
            end else begin
                bus.x = '0; bus.y = '0; bus.video_on = 1'b0;
            end
        end
        drive_idle();
        m_dig[0] = v / 100;
        m_dig[1] = (v / 10) % 10;
        m_dig[2] = v % 10;
    endtask

    task automatic run_reset_mid_conv(input int sc);
        for (int t = 0; t <= 7; t++) begin
            step();
            if (t == 6) check("busy_after_rst", int'(bus.busy), 0);
            if (t == 7) check("digit_after_rst", int'(bus.rom_sel), 0);
            drive_idle();
            reset = (t == 5);
            if (t == 0) begin bus.score_load = 1'b1; bus.score = 10'(sc); end
            if (t == 6) begin bus.x = 10'(X0 + 60); bus.y = 10'(Y0); bus.video_on = 1'b1; end
        end
        drive_idle();
        m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (t > 0) check("busy_idle", int'(bus.busy), 0);
            bus.frame_start = (t == 3) || (t == 15);
        end
        drive_idle();
    endtask

    initial begin
        int sc, fd, ex, ef;
        reset = 1'b1;
        drive_idle();
        m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 0;
        step(); step();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_row", int'(bus.rom_row), 0);
        check("rst_col", int'(bus.rom_col), 0);
        check("rst_sel", int'(bus.rom_sel), 0);
        check("rst_pix", int'(bus.pixel_on), 0);
        check("rst_color", int'(bus.pixel_color), 0);
        reset = 1'b0;

        set_edges();
        run_scan(300, 8);

        run_update(307, 15, -1, 0, -1);
        set_edges();
        run_scan(250, 8);

        run_update(1023, 11, -1, 0, 4);
        set_edges();
        run_scan(200, 8);

        run_update(5, 13, 4, 888, 6);
        set_edges();
        run_scan(250, 8);

        run_reset_mid_conv(642);
        sx[0] = X0 + 60; sy[0] = Y0; sv[0] = 0;
        run_scan(150, 1);

        for (int i = 0; i < 6; i++) begin
            sc = $urandom_range(0, 1023);
            fd = $urandom_range(11, 20);
            ex = ($urandom % 2) ? $urandom_range(1, fd + 1) : -1;
            ef = ($urandom % 2) ? $urandom_range(1, 10) : -1;
            run_update(sc, fd, ex, $urandom_range(0, 1023), ef);
            set_edges();
            run_scan(150, 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
